// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter setpoint sequencer.
// Holds the controller state encoding, default parameter values, the step
// direction constants driven onto on_off, and the target clamp helper.
package counter_ctrl_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_STEP_DIV = 4;
  localparam int DEF_MIN_VAL  = 0;
  localparam int DEF_MAX_VAL  = 255;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    STEP,
    WAIT,
    DONE
  } state_t;

  // Comparison is done in the int domain so a zero lower bound does not
  // turn into an always-false unsigned compare.
  function automatic int clamp_val(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/counter_setpoint_ctrl_step_timer.sv
// step_timer: loadable down-counter that paces the WAIT phase between steps.
// Ports:
//   clk, rst   shared clock and asynchronous active-high reset
//   load       load load_val this cycle (asserted on the STEP that enters WAIT)
//   load_val   number of WAIT cycles to spend
//   expired    high during the last WAIT cycle
module step_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // The value loaded is the WAIT length, so the first WAIT cycle sees the
  // full count and the last one sees 1; it idles at 0 between uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/counter_setpoint_ctrl.sv
// counter_setpoint_ctrl: walks an external up/down counter toward a requested
// target one count at a time, reading the live value back before every step.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_target  target offer from the front end
//   req_ready             high only while idle
//   abort                 cancel the operation in progress
//   counter_in            live counter value
//   change/on_off         step pulse and direction to the counter (1 = up)
//   busy                  operation in progress
//   done                  one-cycle pulse on arrival
//   step_cnt              steps issued in the current/last operation (saturating)
module counter_setpoint_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STEP_DIV = DEF_STEP_DIV,
  parameter int MIN_VAL  = DEF_MIN_VAL,
  parameter int MAX_VAL  = DEF_MAX_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_target,
  output logic             req_ready,
  input  logic             abort,
  input  logic [WIDTH-1:0] counter_in,
  output logic             change,
  output logic             on_off,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] step_cnt
);

  localparam int TIMER_W  = (STEP_DIV < 2) ? 1 : $clog2(STEP_DIV);
  localparam bit USE_WAIT = (STEP_DIV > 1);
  localparam logic [TIMER_W-1:0] WAIT_LEN = TIMER_W'((STEP_DIV > 1) ? STEP_DIV - 1 : 0);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] clamped;
  logic             go_up;
  logic             timer_load;
  logic             timer_expired;

  assign clamped    = WIDTH'(clamp_val(int'(req_target), MIN_VAL, MAX_VAL));
  assign go_up      = (target > counter_in);
  assign timer_load = (state == STEP) && (next_state == WAIT);

  step_timer #(.W(TIMER_W)) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (WAIT_LEN),
    .expired  (timer_expired)
  );

  // Next-state logic. The wrap guard refuses a step that would roll the
  // counter over and finishes instead; abort overrides everything outside IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) next_state = COMPARE;
      end
      COMPARE: begin
        if (counter_in == target) begin
          next_state = DONE;
        end else if ((go_up && (counter_in == '1)) || (!go_up && (counter_in == '0))) begin
          next_state = DONE;
        end else begin
          next_state = STEP;
        end
      end
      STEP: begin
        next_state = USE_WAIT ? WAIT : COMPARE;
      end
      WAIT: begin
        if (timer_expired) next_state = COMPARE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) next_state = IDLE;
  end

  // State, latched target, registered direction and step counter. The
  // direction is only refreshed when a step is actually about to be issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      target   <= '0;
      on_off   <= DIR_DOWN;
      step_cnt <= '0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && req_valid) begin
        target   <= clamped;
        step_cnt <= '0;
      end else if ((state == STEP) && (step_cnt != '1)) begin
        step_cnt <= step_cnt + WIDTH'(1);
      end
      if ((state == COMPARE) && (next_state == STEP)) begin
        on_off <= go_up ? DIR_UP : DIR_DOWN;
      end
    end
  end

  assign change    = (state == STEP);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign req_ready = (state == IDLE);

endmodule
